instr_fetch_unit: RTL and testbench

- Instruction-side front end for the processor datapath.
- Owns the program counter and issues word reads to instruction memory over a req/ready + rvalid handshake.
- Buffers returned words in a small FIFO and presents them to decode/control as a valid/ready stream of {instr, pc}.
- Supports taken-branch/jump redirects, including discarding a response that is still in flight.

---
 rtl/instr_fetch_unit.sv | 194 +++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Instruction-side front end. It owns the program counter and issues one
//   word read at a time over a req/ready + rvalid handshake. Returned words
//   go into a small first-word-fall-through FIFO, which is presented
//   downstream as a valid/ready stream of {instr, pc}. A redirect flushes
//   the FIFO and restarts fetch. If a response is still in flight when the
//   redirect arrives, that response is dropped.
//
// Optional feature (macro IFU_PERF_COUNT_EN):
//   Adds fetch_count (FIFO pops) and flush_count (redirect pulses). Both
//   counters wrap.
//
// Ports:
//   CLK, RESET         clock (rising edge); asynchronous active-high reset
//   mem_req/mem_addr   read request and word-aligned byte address
//   mem_ready          memory accepts the request this cycle
//   mem_rvalid/rdata   read response
//   instr_valid/instr/instr_pc   head of the instruction FIFO
//   instr_ready        consumer pops the head this cycle
//   redirect/redirect_pc         one-cycle flush-and-restart request
//   fetch_count/flush_count      performance counters (IFU_PERF_COUNT_EN only)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       BUF_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFU_PERF_COUNT_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [15:0]       flush_count
`endif
);

    localparam int unsigned       PTR_W    = $clog2(BUF_DEPTH);
    localparam int unsigned       CNT_W    = PTR_W + 1;
    localparam logic [ADDR_W-1:0] START_PC = {RESET_PC[ADDR_W-1:2], 2'b00};
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_STALL = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              go_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d, count_after;
    logic [31:0]       buf_instr_q [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_pc_q    [BUF_DEPTH];

    logic              fetch_hs;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] redirect_pc_al;
    logic              unused_redirect_lsb;

    assign redirect_pc_al      = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // go_q holds off the first request until the first clock edge after
    // reset is released. This keeps mem_req low while reset is asserted,
    // even though the FSM already sits in FETCH.
    assign fetch_hs = go_q && (state_q == S_FETCH) && mem_ready;

    // Only a response that belongs to a live WAIT is pushed. A response
    // drained after a redirect, or one that arrives after reset, never
    // reaches the FIFO.
    assign push = (state_q == S_WAIT) && mem_rvalid && !redirect;
    assign pop  = (count_q != '0) && instr_ready && !redirect;

    assign count_after = count_q + CNT_W'(push) - CNT_W'(pop);

    // State register, PC and FIFO control
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_FETCH;
            go_q     <= 1'b0;
            pc_q     <= START_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            go_q     <= 1'b1;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage holds data only, so it needs no reset
    always_ff @(posedge CLK) begin
        if (push) begin
            buf_instr_q[wr_ptr_q] <= mem_rdata;
            buf_pc_q[wr_ptr_q]    <= pc_q;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                // A redirect that coincides with the handshake still leaves
                // one response in flight, and that response must be dropped.
                if (fetch_hs) state_d = redirect ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (redirect)        state_d = mem_rvalid ? S_FETCH : S_DRAIN;
                else if (mem_rvalid) state_d = (count_after < FULL_CNT) ? S_FETCH : S_STALL;
            end
            S_STALL: begin
                if (redirect || (count_q < FULL_CNT)) state_d = S_FETCH;
            end
            S_DRAIN: begin
                if (mem_rvalid) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // PC and FIFO pointer next state; a redirect overrides any push or pop
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            pc_d     = redirect_pc_al;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + ADDR_W'(4);
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_after;
        end
    end

    // Outputs
    always_comb begin
        mem_req     = go_q && (state_q == S_FETCH);
        mem_addr    = pc_q;
        instr_valid = (count_q != '0);
        instr       = '0;
        instr_pc    = '0;
        if (count_q != '0) begin
            instr    = buf_instr_q[rd_ptr_q];
            instr_pc = buf_pc_q[rd_ptr_q];
        end
    end

`ifdef IFU_PERF_COUNT_EN
    logic [31:0] fetch_count_q;
    logic [15:0] flush_count_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (pop)      fetch_count_q <= fetch_count_q + 32'd1;
            if (redirect) flush_count_q <= flush_count_q + 16'd1;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Self-checking bench for instr_fetch_unit. The memory model answers each
//   accepted request after a configurable latency, and each memory word is a
//   fixed function of its address. The reference model tracks only the
//   expected stream: after reset or a redirect, the delivered entries must
//   be pc, pc+4, ... and each instruction must equal the word stored at its
//   pc. Protocol rules are checked every cycle. Directed scenarios cover
//   reset, latency, back-pressure, redirects, reset during a pending read
//   and PC wrap. A randomized run follows them.
//   Define IFU_PERF_COUNT_EN to also check the performance counters.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK;
    logic        RESET;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef IFU_PERF_COUNT_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
`endif

    instr_fetch_unit #(
        .ADDR_W    (32),
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (2)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef IFU_PERF_COUNT_EN
        ,
        .fetch_count (fetch_count),
        .flush_count (flush_count)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- bench state ----------------
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rdy_pct = 100;
    bit          lat_rand = 0;
    int          lat_fix = 1;
    // memory model
    bit          pend = 0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    // reference stream model and bookkeeping
    logic [31:0] exp_pc = RESET_PC;
    int          n_hs = 0;
    int          n_pop = 0;
    int          n_redir = 0;
    logic [31:0] hs_q[$];
    int          first_hs_cyc = -1;
    int          first_vld_cyc = -1;
    logic [31:0] first_vld_instr = '0;
    logic [31:0] first_vld_pc = '0;
    logic [31:0] last_pop_pc = '0;
    logic [31:0] last_pop_instr = '0;
    bit          prev_req_stall = 0;
    logic [31:0] prev_addr = '0;
    bit          prev_hold = 0;
    logic [31:0] prev_instr = '0;
    logic [31:0] prev_ipc = '0;

    // Memory contents: two fixed words at 0 and 4. Everywhere else, an
    // odd-multiplier hash that is unique per address.
    function automatic logic [31:0] mw(input logic [31:0] a);
        if (a == 32'h0) return 32'h0800_0000;
        if (a == 32'h4) return 32'h0880_0000;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] q_at(input int i);
        if (i < hs_q.size()) return hs_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle. Entered and left at a negedge. The test code sets
    // instr_ready, redirect and redirect_pc before the call; the memory side
    // is driven here.
    task automatic step();
        bit hs;
        bit pop;
        mem_ready  = ($urandom_range(0, 99) < rdy_pct);
        mem_rvalid = pend && (cnt == 0);
        mem_rdata  = mem_rvalid ? mw(paddr) : $urandom;

        if (!RESET) begin
            if (prev_req_stall) begin
                check("req_hold", mem_req, 1);
                check("addr_hold", mem_addr, prev_addr);
            end
            if (prev_hold) begin
                check("vld_hold", instr_valid, 1);
                check("instr_hold", instr, prev_instr);
                check("ipc_hold", instr_pc, prev_ipc);
            end
            if (mem_req) check("addr_align", mem_addr[1:0], 0);
            if (instr_valid && first_vld_cyc < 0) begin
                first_vld_cyc   = cyc;
                first_vld_instr = instr;
                first_vld_pc    = instr_pc;
            end
        end

        hs  = mem_req && mem_ready;
        pop = instr_valid && instr_ready && !redirect;

        if (mem_rvalid) pend = 0;
        else if (pend) cnt--;

        if (hs) begin
            check("one_outstanding", pend, 0);
            pend  = 1;
            paddr = mem_addr;
            cnt   = (lat_rand ? $urandom_range(1, 3) : lat_fix) - 1;
            hs_q.push_back(mem_addr);
            n_hs++;
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
        end
        if (pop) begin
            check("stream_pc", instr_pc, exp_pc);
            check("stream_instr", instr, mw(exp_pc));
            last_pop_pc    = instr_pc;
            last_pop_instr = instr;
            exp_pc         = exp_pc + 32'd4;
            n_pop++;
        end
        if (redirect && !RESET) begin
            exp_pc = {redirect_pc[31:2], 2'b00};
            n_redir++;
        end

        prev_req_stall = mem_req && !mem_ready && !redirect && !RESET;
        prev_addr      = mem_addr;
        prev_hold      = instr_valid && !instr_ready && !redirect && !RESET;
        prev_instr     = instr;
        prev_ipc       = instr_pc;
        cyc++;
        @(negedge CLK);
    endtask

    task automatic do_reset(input int n);
        RESET      = 1'b1;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        redirect   = 1'b0;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, RESET_PC);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        @(negedge CLK);
        exp_pc         = RESET_PC;
        n_hs           = 0;
        n_pop          = 0;
        n_redir        = 0;
        hs_q.delete();
        first_hs_cyc   = -1;
        first_vld_cyc  = -1;
        prev_req_stall = 0;
        prev_hold      = 0;
        repeat (n) step();
        RESET = 1'b0;
    endtask

    task automatic wait_hs(input string tag, input int max);
        int start = n_hs;
        int k = 0;
        while (n_hs == start && k < max) begin
            step();
            k++;
        end
        check(tag, (n_hs != start), 1);
    endtask

    task automatic wait_pop(input string tag, input int max);
        int start = n_pop;
        int k = 0;
        while (n_pop == start && k < max) begin
            step();
            k++;
        end
        check(tag, (n_pop != start), 1);
    endtask

    initial begin
        int p0;
        RESET       = 1'b0;
        mem_ready   = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        @(negedge CLK);

        // Basic fetch: addresses 0, 4, 8; first data 2 cycles after handshake; 1 per 2 cycles
        rdy_pct = 100; lat_rand = 0; lat_fix = 1; instr_ready = 1;
        do_reset(3);
        repeat (6) step();
        check("t1_addr0", q_at(0), 32'h0);
        check("t1_addr1", q_at(1), 32'h4);
        check("t1_addr2", q_at(2), 32'h8);
        check("t1_latency", first_vld_cyc - first_hs_cyc, 2);
        check("t1_first_instr", first_vld_instr, 32'h0800_0000);
        check("t1_first_pc", first_vld_pc, 32'h0);
        check("t1_second_instr", last_pop_instr, 32'h0880_0000);
        check("t1_second_pc", last_pop_pc, 32'h4);
        p0 = n_pop;
        repeat (10) step();
        check("t1_rate", n_pop - p0, 5);

        // Back-pressure: exactly two entries buffered, no request until a pop
        instr_ready = 0;
        do_reset(3);
        repeat (12) step();
        check("t2_two_reqs", n_hs, 2);
        check("t2_req_low", mem_req, 0);
        check("t2_valid", instr_valid, 1);
        check("t2_head_pc", instr_pc, 32'h0);
        check("t2_head_instr", instr, 32'h0800_0000);
        instr_ready = 1;
        step();
        instr_ready = 0;
        check("t2_req_low_after_pop", n_hs, 2);
        wait_hs("t2_refetch_timeout", 6);
        check("t2_refetch_addr", q_at(hs_q.size() - 1), 32'h8);
        instr_ready = 1;
        repeat (10) step();

        // Redirect while waiting; the stale response is dropped (DRAIN and direct paths)
        for (int lat = 2; lat >= 1; lat--) begin
            lat_fix = lat; instr_ready = 1;
            do_reset(3);
            wait_hs("t3_hs_timeout", 5);
            redirect = 1; redirect_pc = 32'h100;
            step();
            redirect = 0;
            hs_q.delete();
            wait_hs("t3_refetch_timeout", 6);
            check("t3_new_addr", q_at(0), 32'h100);
            wait_pop("t3_pop_timeout", 10);
            check("t3_first_pc", last_pop_pc, 32'h100);
        end

        // Redirect with two entries buffered and a simultaneous pop
        lat_fix = 1; instr_ready = 0;
        do_reset(3);
        repeat (12) step();
        check("t4_full_valid", instr_valid, 1);
        redirect = 1; redirect_pc = 32'h203; instr_ready = 1;
        step();
        redirect = 0; instr_ready = 0;
        check("t4_flush_valid", instr_valid, 0);
        hs_q.delete();
        wait_hs("t4_hs_timeout", 4);
        check("t4_addr", q_at(0), 32'h200);
        instr_ready = 1;
        wait_pop("t4_pop_timeout", 8);
        check("t4_first_pc", last_pop_pc, 32'h200);

        // Reset while a read is pending; its response arrives after release
        lat_fix = 1; instr_ready = 1;
        do_reset(3);
        redirect = 1; redirect_pc = 32'h40;
        step();
        redirect = 0;
        lat_fix = 3;
        hs_q.delete();
        wait_hs("t5_hs_timeout", 6);
        check("t5_pending_addr", q_at(0), 32'h40);
        lat_fix = 1;
        do_reset(1);
        check("t5_valid_after_reset", instr_valid, 0);
        wait_hs("t5_restart_timeout", 4);
        check("t5_restart_addr", q_at(0), RESET_PC);
        wait_pop("t5_pop_timeout", 8);
        check("t5_first_pc", last_pop_pc, RESET_PC);
        check("t5_first_instr", last_pop_instr, mw(RESET_PC));

        // PC wrap at the top of the address space
        do_reset(3);
        redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 0;
        hs_q.delete();
        repeat (8) step();
        check("t6_addr_top", q_at(0), 32'hFFFF_FFFC);
        check("t6_addr_wrap", q_at(1), 32'h0);

`ifdef IFU_PERF_COUNT_EN
        // Performance counters: 5 pops and 2 redirects
        do_reset(3);
        instr_ready = 1;
        for (int k = 0; k < 40 && n_pop < 5; k++) step();
        instr_ready = 0;
        redirect = 1; redirect_pc = 32'h300;
        step();
        step();
        redirect = 0;
        step();
        check("perf_fetch_count", fetch_count, 5);
        check("perf_flush_count", flush_count, 2);
`endif

        // Randomized run: random ready, latency, back-pressure and redirects
        rdy_pct = 70; lat_rand = 1;
        do_reset(3);
        for (int k = 0; k < 3000; k++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 39) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                       : $urandom;
            step();
        end
        redirect = 0;
        check("rand_progress", (n_pop > 300), 1);
`ifdef IFU_PERF_COUNT_EN
        check("rand_fetch_count", fetch_count, n_pop);
        check("rand_flush_count", flush_count, n_redir[15:0]);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
